// File: rtl/aux_timer_arbiter_if.sv
// ---------------------------------------------------------------------------
// aux_timer_arbiter_if
// Bundles the signals that the timer arbiter uses to talk to the game-control
// requesters and to the shared aux_timer.
//   req, req_dur, cancel   requester -> arbiter (level request, duration, abort)
//   gnt, done              arbiter -> requesters (one-hot grant, expiry pulse)
//   busy, owner            arbiter status
//   timer_loadN/data/ena   arbiter -> aux_timer controls
//   timer_tc               aux_timer -> arbiter terminal count
// Modport slave is the arbiter side; modport master is the requester/timer side.
// ---------------------------------------------------------------------------
interface aux_timer_arbiter_if #(
    parameter int N_REQ = 4
) ();
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_dur;
    logic [N_REQ-1:0]   cancel;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   done;
    logic               busy;
    logic [OW-1:0]      owner;
    logic               timer_loadN;
    logic [7:0]         timer_data;
    logic               timer_ena_cnt;
    logic               timer_tc;

    modport slave (
        input  req, req_dur, cancel, timer_tc,
        output gnt, done, busy, owner, timer_loadN, timer_data, timer_ena_cnt
    );

    modport master (
        output req, req_dur, cancel, timer_tc,
        input  gnt, done, busy, owner, timer_loadN, timer_data, timer_ena_cnt
    );
endinterface

// File: rtl/aux_timer_arbiter.sv
// ---------------------------------------------------------------------------
// aux_timer_arbiter
// Shares one 8-bit loadable down counter (aux_timer) among N_REQ requesters.
// A round-robin pick chooses the next owner, its duration is loaded into the
// timer, the countdown is paced by a TICK_DIV prescaler, and the owner gets a
// one-cycle done pulse when the timer reaches zero. The owner may abort its
// interval with cancel, which zeroes the shared timer without a done pulse.
// Ports:
//   clk     system clock
//   resetN  asynchronous active-low reset
//   bus     aux_timer_arbiter_if.slave (requester and aux_timer signals)
// ---------------------------------------------------------------------------
module aux_timer_arbiter #(
    parameter int N_REQ    = 4,
    parameter int TICK_DIV = 250000
) (
    input  logic                 clk,
    input  logic                 resetN,
    aux_timer_arbiter_if.slave   bus
);
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [OW-1:0] LAST_IDX = OW'(N_REQ - 1);
    localparam logic [PW-1:0] PS_MAX   = PW'(TICK_DIV - 1);
    localparam logic [OW:0]   N_WIDE   = (OW + 1)'(N_REQ);

    typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, DONE, CLEAR} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   rrPtr_q, rrPtr_d;
    logic [7:0]      timerData_q, timerData_d;
    logic [PW-1:0]   prescaler_q, prescaler_d;

    logic [OW:0]     rrSum;
    logic [OW-1:0]   rrCand;
    logic [OW-1:0]   pickIdx;
    logic            pickValid;
    logic [OW-1:0]   nextPtr;
    logic [N_REQ-1:0] ownerHot;
    logic            tickPulse;
    logic            ownerCancel;

    // Round-robin search: first set req bit at or above rrPtr, wrapping.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = '0;
        rrSum     = '0;
        rrCand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rrSum = {1'b0, rrPtr_q} + (OW + 1)'(k);
            if (rrSum >= N_WIDE) begin
                rrSum = rrSum - N_WIDE;
            end
            rrCand = rrSum[OW-1:0];
            if (!pickValid && bus.req[rrCand]) begin
                pickValid = 1'b1;
                pickIdx   = rrCand;
            end
        end
    end

    always_comb begin
        ownerHot          = '0;
        ownerHot[owner_q] = 1'b1;
    end

    assign nextPtr     = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
    assign tickPulse   = (state_q == RUN) && (prescaler_q == PS_MAX);
    assign ownerCancel = bus.cancel[owner_q];

    // Next-state logic. Cancel takes priority over tc in both ARM and RUN so
    // an abort always leaves the shared timer cleared.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rrPtr_d     = rrPtr_q;
        timerData_d = timerData_q;
        prescaler_d = prescaler_q;
        case (state_q)
            IDLE: begin
                if (pickValid) begin
                    owner_d     = pickIdx;
                    timerData_d = bus.req_dur[int'(pickIdx)*8 +: 8];
                    state_d     = LOAD;
                end
            end
            LOAD: state_d = ARM;
            ARM: begin
                if (ownerCancel) begin
                    state_d = CLEAR;
                end else if (bus.timer_tc) begin
                    state_d = DONE;
                end else begin
                    prescaler_d = '0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                prescaler_d = tickPulse ? '0 : prescaler_q + 1'b1;
                if (ownerCancel) begin
                    state_d = CLEAR;
                end else if (bus.timer_tc) begin
                    state_d = DONE;
                end
            end
            DONE, CLEAR: begin
                rrPtr_d = nextPtr;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rrPtr_q     <= '0;
            timerData_q <= '0;
            prescaler_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rrPtr_q     <= rrPtr_d;
            timerData_q <= timerData_d;
            prescaler_q <= prescaler_d;
        end
    end

    // Outputs decode registered state only; CLEAR forces zero onto the timer.
    assign bus.gnt           = (state_q != IDLE) ? ownerHot : '0;
    assign bus.done          = (state_q == DONE) ? ownerHot : '0;
    assign bus.busy          = (state_q != IDLE);
    assign bus.owner         = (state_q == IDLE) ? '0 : owner_q;
    assign bus.timer_loadN   = !((state_q == LOAD) || (state_q == CLEAR));
    assign bus.timer_data    = (state_q == CLEAR) ? 8'h00 : timerData_q;
    assign bus.timer_ena_cnt = tickPulse;
endmodule

// File: tb/tb_aux_timer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_aux_timer_arbiter
// Directed bench for aux_timer_arbiter with N_REQ=4, TICK_DIV=4. A small
// behavioural aux_timer (load on loadN low, decrement on ena_cnt, tc at zero)
// closes the loop so expiry timing can be checked against hand-computed
// cycle counts measured from the LOAD cycle.
// ---------------------------------------------------------------------------
module tb_aux_timer_arbiter;
    localparam int N  = 4;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic resetN;
    logic [7:0] timerCnt;

    int checkCount = 0;
    int failCount  = 0;

    int doneCyc, pulses, firstPulse, lastPulse;
    logic [3:0] doneVal, gntAtDone, doneSeen;

    always #5 clk = ~clk;

    aux_timer_arbiter_if #(.N_REQ(N)) bus ();

    aux_timer_arbiter #(.N_REQ(N), .TICK_DIV(TD)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    // Behavioural model of the shared aux_timer.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            timerCnt <= 8'd0;
        end else if (!bus.timer_loadN) begin
            timerCnt <= bus.timer_data;
        end else if (bus.timer_ena_cnt && timerCnt != 8'd0) begin
            timerCnt <= timerCnt - 8'd1;
        end
    end
    assign bus.timer_tc = (timerCnt == 8'd0);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] c);
        bus.req    = r;
        bus.cancel = c;
    endtask

    task automatic setDur(input int i, input logic [7:0] d);
        bus.req_dur[i*8 +: 8] = d;
    endtask

    // Steps cycles after LOAD (cycle startCyc) until a done pulse or timeout.
    task automatic waitDone(input int startCyc, output int dCyc, output int nPulse,
                            output int fPulse, output int lPulse,
                            output logic [3:0] dVal, output logic [3:0] gVal);
        dCyc = -1; nPulse = 0; fPulse = -1; lPulse = -1; dVal = '0; gVal = '0;
        for (int k = startCyc + 1; k <= startCyc + 200; k++) begin
            tick();
            if (bus.timer_ena_cnt) begin
                nPulse++;
                if (fPulse < 0) fPulse = k;
                lPulse = k;
            end
            if (bus.done != '0) begin
                dCyc = k;
                dVal = bus.done;
                gVal = bus.gnt;
                break;
            end
        end
    endtask

    initial begin
        resetN      = 1'b0;
        bus.req     = '0;
        bus.cancel  = '0;
        bus.req_dur = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_gnt",   32'(bus.gnt), 0);
        checkOutput("rst_done",  32'(bus.done), 0);
        checkOutput("rst_busy",  32'(bus.busy), 0);
        checkOutput("rst_owner", 32'(bus.owner), 0);
        checkOutput("rst_loadN", 32'(bus.timer_loadN), 1);
        checkOutput("rst_data",  32'(bus.timer_data), 0);
        checkOutput("rst_ena",   32'(bus.timer_ena_cnt), 0);
        resetN = 1'b1;
        tick();

        // Scenario 1: single requester 0, duration 3.
        setDur(0, 8'd3);
        applyStimulus(4'b0001, 4'b0000);
        tick();
        checkOutput("t1_gnt",   32'(bus.gnt), 1);
        checkOutput("t1_loadN", 32'(bus.timer_loadN), 0);
        checkOutput("t1_data",  32'(bus.timer_data), 3);
        checkOutput("t1_busy",  32'(bus.busy), 1);
        applyStimulus(4'b0000, 4'b0000);
        tick();
        checkOutput("t1_arm_loadN", 32'(bus.timer_loadN), 1);
        waitDone(1, doneCyc, pulses, firstPulse, lastPulse, doneVal, gntAtDone);
        checkOutput("t1_done_cyc", 32'(doneCyc), 15);
        checkOutput("t1_pulses",   32'(pulses), 3);
        checkOutput("t1_first_ena", 32'(firstPulse), 5);
        checkOutput("t1_last_ena",  32'(lastPulse), 13);
        checkOutput("t1_done_val", 32'(doneVal), 1);
        checkOutput("t1_gnt_at_done", 32'(gntAtDone), 1);
        tick();
        checkOutput("t1_idle_gnt",  32'(bus.gnt), 0);
        checkOutput("t1_idle_busy", 32'(bus.busy), 0);

        // Scenario 2: requester 1 with zero duration.
        setDur(1, 8'd0);
        applyStimulus(4'b0010, 4'b0000);
        tick();
        checkOutput("t2_owner", 32'(bus.owner), 1);
        checkOutput("t2_gnt",   32'(bus.gnt), 2);
        checkOutput("t2_data",  32'(bus.timer_data), 0);
        applyStimulus(4'b0000, 4'b0000);
        waitDone(0, doneCyc, pulses, firstPulse, lastPulse, doneVal, gntAtDone);
        checkOutput("t2_done_cyc", 32'(doneCyc), 2);
        checkOutput("t2_pulses",   32'(pulses), 0);
        checkOutput("t2_done_val", 32'(doneVal), 2);
        tick();

        // Scenario 3: all four requesting from a fresh reset, duration 1 each.
        resetN = 1'b0;
        #2;
        resetN = 1'b1;
        tick();
        for (int i = 0; i < N; i++) setDur(i, 8'd1);
        applyStimulus(4'b1111, 4'b0000);
        for (int g = 0; g < 5; g++) begin
            tick();
            checkOutput($sformatf("t3_owner_%0d", g), 32'(bus.owner), 32'(g % 4));
            checkOutput($sformatf("t3_gnt_%0d", g), 32'(bus.gnt), 32'(1 << (g % 4)));
            waitDone(0, doneCyc, pulses, firstPulse, lastPulse, doneVal, gntAtDone);
            checkOutput($sformatf("t3_done_cyc_%0d", g), 32'(doneCyc), 7);
            checkOutput($sformatf("t3_done_val_%0d", g), 32'(doneVal), 32'(1 << (g % 4)));
            checkOutput($sformatf("t3_pulses_%0d", g), 32'(pulses), 1);
            tick();
            checkOutput($sformatf("t3_gap_busy_%0d", g), 32'(bus.busy), 0);
        end
        applyStimulus(4'b0000, 4'b0000);

        // Scenario 4: owner 2 cancels 8 cycles into RUN; requester 3 is next.
        setDur(2, 8'd10);
        setDur(3, 8'd1);
        applyStimulus(4'b1100, 4'b0000);
        tick();
        checkOutput("t4_owner", 32'(bus.owner), 2);
        doneSeen = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            doneSeen = doneSeen | bus.done;
        end
        applyStimulus(4'b1000, 4'b0100);
        tick();
        checkOutput("t4_no_done_run", 32'(doneSeen), 0);
        checkOutput("t4_clr_loadN", 32'(bus.timer_loadN), 0);
        checkOutput("t4_clr_data",  32'(bus.timer_data), 0);
        checkOutput("t4_clr_gnt",   32'(bus.gnt), 4);
        checkOutput("t4_clr_done",  32'(bus.done), 0);
        applyStimulus(4'b1000, 4'b0000);
        tick();
        checkOutput("t4_idle_busy", 32'(bus.busy), 0);
        checkOutput("t4_idle_done", 32'(bus.done), 0);
        checkOutput("t4_timer_zero", 32'(bus.timer_tc), 1);
        tick();
        checkOutput("t4_next_owner", 32'(bus.owner), 3);
        applyStimulus(4'b0000, 4'b0000);
        waitDone(0, doneCyc, pulses, firstPulse, lastPulse, doneVal, gntAtDone);
        checkOutput("t4_done_cyc", 32'(doneCyc), 7);
        checkOutput("t4_done_val", 32'(doneVal), 8);
        tick();

        // Scenario 5: non-owner cancel is ignored.
        setDur(0, 8'd2);
        applyStimulus(4'b0001, 4'b0000);
        tick();
        checkOutput("t5_owner", 32'(bus.owner), 0);
        applyStimulus(4'b0000, 4'b0010);
        waitDone(0, doneCyc, pulses, firstPulse, lastPulse, doneVal, gntAtDone);
        checkOutput("t5_done_cyc", 32'(doneCyc), 11);
        checkOutput("t5_done_val", 32'(doneVal), 1);
        checkOutput("t5_pulses",   32'(pulses), 2);
        applyStimulus(4'b0000, 4'b0000);
        tick();

        // Scenario 6: asynchronous reset mid-RUN, then restart from index 0.
        setDur(2, 8'd5);
        applyStimulus(4'b0100, 4'b0000);
        tick();
        checkOutput("t6_owner", 32'(bus.owner), 2);
        applyStimulus(4'b0000, 4'b0000);
        repeat (5) tick();
        checkOutput("t6_pre_busy", 32'(bus.busy), 1);
        resetN = 1'b0;
        #1;
        checkOutput("t6_rst_gnt",   32'(bus.gnt), 0);
        checkOutput("t6_rst_busy",  32'(bus.busy), 0);
        checkOutput("t6_rst_owner", 32'(bus.owner), 0);
        checkOutput("t6_rst_loadN", 32'(bus.timer_loadN), 1);
        checkOutput("t6_rst_data",  32'(bus.timer_data), 0);
        checkOutput("t6_rst_ena",   32'(bus.timer_ena_cnt), 0);
        checkOutput("t6_rst_done",  32'(bus.done), 0);
        tick();
        checkOutput("t6_hold_done", 32'(bus.done), 0);
        resetN = 1'b1;
        setDur(0, 8'd0);
        applyStimulus(4'b1001, 4'b0000);
        tick();
        checkOutput("t6_restart_owner", 32'(bus.owner), 0);
        checkOutput("t6_restart_gnt",   32'(bus.gnt), 1);
        applyStimulus(4'b0000, 4'b0000);
        waitDone(0, doneCyc, pulses, firstPulse, lastPulse, doneVal, gntAtDone);
        checkOutput("t6_done_cyc", 32'(doneCyc), 2);
        checkOutput("t6_done_val", 32'(doneVal), 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
